lut_neuron_layer_pipe: RTL and testbench



---
 rtl/lut_neuron_layer_pipe.sv | 133 +++++++++++++
 tb/tb_lut_neuron_layer_pipe.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_neuron_layer_pipe.sv
// Layer of NEURONS LUT neurons with runtime-loadable truth tables and a one-cycle valid/ready lookup stage.
// Optional build macro LUT_PARITY_EN adds a per-entry even-parity bit and a sticky par_err output.
module lut_neuron_layer_pipe #(
    parameter int NEURONS  = 4,
    parameter int IN_BITS  = 8,
    parameter int OUT_BITS = 1,
    parameter int NW       = (NEURONS > 1) ? $clog2(NEURONS) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         cfg_we,
    input  logic [NW-1:0]                cfg_neuron,
    input  logic [IN_BITS-1:0]           cfg_addr,
    input  logic [OUT_BITS-1:0]          cfg_data,
    input  logic                         cfg_done,
    input  logic                         cfg_reload,
    output logic                         cfg_err,
    output logic                         run,
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [NEURONS*IN_BITS-1:0]   s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [NEURONS*OUT_BITS-1:0]  m_data
`ifdef LUT_PARITY_EN
    ,
    output logic                         par_err
`endif
);

    localparam int IW    = (NEURONS > 1) ? $clog2(NEURONS) : 1;
    localparam int DEPTH = 1 << IN_BITS;
`ifdef LUT_PARITY_EN
    localparam int EW = OUT_BITS + 1;
`else
    localparam int EW = OUT_BITS;
`endif

    typedef enum logic [1:0] {LOAD, RUN, DRAIN} state_t;

    state_t state;
    state_t state_next;

    logic [EW-1:0]               mem [NEURONS][DEPTH];
    logic [EW-1:0]               wr_entry;
    logic [NEURONS*OUT_BITS-1:0] lut_out;
    logic                        cfg_legal;
    logic                        wr_en;
    logic                        accept;

    function automatic logic even_par(input logic [OUT_BITS-1:0] d);
        return ^d;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) state <= LOAD;
        else     state <= state_next;
    end

    // DRAIN waits until the last pending output has been taken downstream.
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        run        = 1'b0;
        case (state)
            LOAD: begin
                if (cfg_done) state_next = RUN;
            end
            RUN: begin
                run     = 1'b1;
                s_ready = !m_valid | m_ready;
                if (cfg_reload) state_next = DRAIN;
            end
            DRAIN: begin
                if (!m_valid) state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    assign accept    = s_valid & s_ready;
    assign cfg_legal = (int'(cfg_neuron) < NEURONS);
    assign wr_en     = (state == LOAD) & cfg_we & cfg_legal;
`ifdef LUT_PARITY_EN
    assign wr_entry = {even_par(cfg_data), cfg_data};
`else
    assign wr_entry = cfg_data;
`endif

    // Table RAM is deliberately not reset so tables survive rst.
    always_ff @(posedge clk) begin
        if (wr_en) mem[cfg_neuron[IW-1:0]][cfg_addr] <= wr_entry;
    end

`ifdef LUT_PARITY_EN
    logic [NEURONS-1:0] par_bad;
`endif

    for (genvar g = 0; g < NEURONS; g++) begin : g_lut
        logic [EW-1:0] entry;
        assign entry = mem[g][s_data[g*IN_BITS +: IN_BITS]];
        assign lut_out[g*OUT_BITS +: OUT_BITS] = entry[OUT_BITS-1:0];
`ifdef LUT_PARITY_EN
        assign par_bad[g] = entry[OUT_BITS] ^ even_par(entry[OUT_BITS-1:0]);
`endif
    end

    // Lookup stage boundary: registered neuron outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b0;
            m_data  <= '0;
        end else if (accept) begin
            m_valid <= 1'b1;
            m_data  <= lut_out;
        end else if (m_ready) begin
            m_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)                           cfg_err <= 1'b0;
        else if (cfg_we && (state != LOAD || !cfg_legal)) cfg_err <= 1'b1;
    end

`ifdef LUT_PARITY_EN
    always_ff @(posedge clk) begin
        if (rst)                      par_err <= 1'b0;
        else if (accept && |par_bad)  par_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_lut_neuron_layer_pipe.sv
// Scoreboard bench for lut_neuron_layer_pipe (4 neurons, 8-bit fan-in, 1-bit outputs, 3-bit cfg_neuron).
module tb_lut_neuron_layer_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cfg_we = 1'b0;
    logic [2:0]  cfg_neuron = '0;
    logic [7:0]  cfg_addr = '0;
    logic [0:0]  cfg_data = '0;
    logic        cfg_done = 1'b0;
    logic        cfg_reload = 1'b0;
    logic        cfg_err;
    logic        run;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [3:0]  m_data;
`ifdef LUT_PARITY_EN
    logic        par_err;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    logic       model [4][256];
    logic [3:0] sb [$];

    lut_neuron_layer_pipe #(.NEURONS(4), .IN_BITS(8), .OUT_BITS(1), .NW(3)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_neuron(cfg_neuron),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_done(cfg_done),
        .cfg_reload(cfg_reload), .cfg_err(cfg_err), .run(run),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data)
`ifdef LUT_PARITY_EN
        , .par_err(par_err)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [3:0] model_out(input logic [31:0] sd);
        logic [3:0] r;
        for (int n = 0; n < 4; n++) r[n] = model[n][sd[n*8 +: 8]];
        return r;
    endfunction

    // Scoreboard: pop on output handshake, push on input accept.
    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
        end else begin
            if (m_valid && m_ready) begin
                tests_run++;
                if (sb.size() == 0) begin
                    tests_failed++;
                    $display("FAIL sb_extra_output: got m_data=%b, expected no output", m_data);
                end else begin
                    logic [3:0] e;
                    e = sb.pop_front();
                    if (m_data !== e) begin
                        tests_failed++;
                        $display("FAIL sb_data: got m_data=%b, expected %b", m_data, e);
                    end
                end
            end
            if (s_valid && s_ready) sb.push_back(model_out(s_data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_entry(input int n, input int a, input logic d, input logic done);
        cfg_we = 1'b1;
        cfg_neuron = n[2:0];
        cfg_addr = a[7:0];
        cfg_data = d;
        cfg_done = done;
        tick();
        cfg_we = 1'b0;
        cfg_done = 1'b0;
        model[n][a] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        tests_run++;
        if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_m_valid: got %b, expected 0", m_valid); end
        tests_run++;
        if (m_data !== 4'b0000) begin tests_failed++; $display("FAIL reset_m_data: got %b, expected 0000", m_data); end
        tests_run++;
        if (s_ready !== 1'b0) begin tests_failed++; $display("FAIL reset_s_ready: got %b, expected 0", s_ready); end
        tests_run++;
        if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL reset_cfg_err: got %b, expected 0", cfg_err); end
        tests_run++;
        if (run !== 1'b0) begin tests_failed++; $display("FAIL reset_run: got %b, expected 0", run); end
`ifdef LUT_PARITY_EN
        tests_run++;
        if (par_err !== 1'b0) begin tests_failed++; $display("FAIL reset_par_err: got %b, expected 0", par_err); end
`endif
    endtask

    task automatic test_basic_lookup();
        for (int n = 0; n < 4; n++)
            for (int a = 0; a < 256; a++)
                load_entry(n, a, ~a[4], (n == 3) && (a == 255));
        tests_run++;
        if (run !== 1'b1) begin tests_failed++; $display("FAIL basic_run: got %b, expected 1", run); end
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data = 32'h1000_FFEF;
        #1;
        tests_run++;
        if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_s_ready: got %b, expected 1", s_ready); end
        tick();
        s_valid = 1'b0;
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== 4'b0101)
            begin tests_failed++; $display("FAIL basic_out: got v=%b d=%b, expected v=1 d=0101", m_valid, m_data); end
        tick();
        tests_run++;
        if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_drop_valid: got %b, expected 0", m_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vec [3];
        logic        exp0 [3];
        vec[0] = 32'h0000_005A; vec[1] = 32'h0000_0000; vec[2] = 32'h0000_005A;
        exp0[0] = 1'b1; exp0[1] = 1'b0; exp0[2] = 1'b1;
        cfg_reload = 1'b1;
        tick();
        cfg_reload = 1'b0;
        tick();
        for (int a = 0; a < 256; a++)
            if (a != 8'h5A) load_entry(0, a, 1'b0, 1'b0);
        load_entry(0, 8'h5A, 1'b1, 1'b1);
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data = vec[0];
        for (int i = 0; i < 3; i++) begin
            tick();
            tests_run++;
            if (m_valid !== 1'b1 || m_data[0] !== exp0[i] || s_ready !== 1'b1)
                begin tests_failed++; $display("FAIL b2b_%0d: got v=%b d0=%b rdy=%b, expected v=1 d0=%b rdy=1", i, m_valid, m_data[0], s_ready, exp0[i]); end
            if (i < 2) s_data = vec[i+1];
            else       s_valid = 1'b0;
        end
        tick();
        tests_run++;
        if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL b2b_end_valid: got %b, expected 0", m_valid); end
    endtask

    task automatic test_backpressure();
        logic [31:0] x, y;
        x = 32'h0000_105A;
        y = 32'h1010_0000;
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data = x;
        tick();
        s_data = y;
        #1;
        for (int i = 0; i < 3; i++) begin
            tests_run++;
            if (m_valid !== 1'b1 || m_data !== model_out(x) || s_ready !== 1'b0)
                begin tests_failed++; $display("FAIL bp_hold_%0d: got v=%b d=%b rdy=%b, expected v=1 d=%b rdy=0", i, m_valid, m_data, s_ready, model_out(x)); end
            tick();
        end
        m_ready = 1'b1;
        #1;
        tests_run++;
        if (s_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_release_rdy: got %b, expected 1", s_ready); end
        tick();
        s_valid = 1'b0;
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== model_out(y))
            begin tests_failed++; $display("FAIL bp_second: got v=%b d=%b, expected v=1 d=%b", m_valid, m_data, model_out(y)); end
        tick();
        tests_run++;
        if (m_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_end_valid: got %b, expected 0", m_valid); end
    endtask

    task automatic test_drain();
        logic [31:0] x;
        x = 32'h0000_105A;
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data = x;
        tick();
        s_valid = 1'b0;
        cfg_reload = 1'b1;
        tick();
        cfg_reload = 1'b0;
        tests_run++;
        if (run !== 1'b0 || s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== model_out(x))
            begin tests_failed++; $display("FAIL drain_enter: got run=%b rdy=%b v=%b d=%b, expected run=0 rdy=0 v=1 d=%b", run, s_ready, m_valid, m_data, model_out(x)); end
        tick();
        tests_run++;
        if (m_valid !== 1'b1 || run !== 1'b0)
            begin tests_failed++; $display("FAIL drain_hold: got v=%b run=%b, expected v=1 run=0", m_valid, run); end
        m_ready = 1'b1;
        cfg_done = 1'b1;
        tick();
        tests_run++;
        if (m_valid !== 1'b0 || run !== 1'b0)
            begin tests_failed++; $display("FAIL drain_handshake: got v=%b run=%b, expected v=0 run=0", m_valid, run); end
        tick();
        tests_run++;
        if (run !== 1'b0) begin tests_failed++; $display("FAIL drain_exit_timing: got run=%b, expected 0", run); end
        cfg_reload = 1'b1;
        tick();
        cfg_done = 1'b0;
        cfg_reload = 1'b0;
        tests_run++;
        if (run !== 1'b1) begin tests_failed++; $display("FAIL load_done_wins: got run=%b, expected 1", run); end
        cfg_reload = 1'b1;
        tick();
        cfg_reload = 1'b0;
        cfg_done = 1'b1;
        tick();
        tests_run++;
        if (run !== 1'b0) begin tests_failed++; $display("FAIL drain_empty_ignores_done: got run=%b, expected 0", run); end
        tick();
        cfg_done = 1'b0;
        tests_run++;
        if (run !== 1'b1) begin tests_failed++; $display("FAIL drain_one_cycle: got run=%b, expected 1", run); end
    endtask

    task automatic test_cfg_err();
        logic [31:0] v;
        v = 32'h3333_3333;
        cfg_reload = 1'b1;
        tick();
        cfg_reload = 1'b0;
        tick();
        tests_run++;
        if (cfg_err !== 1'b0) begin tests_failed++; $display("FAIL err_clean: got %b, expected 0", cfg_err); end
        cfg_we = 1'b1; cfg_neuron = 3'd5; cfg_addr = 8'h33; cfg_data = 1'b1;
        tick();
        cfg_we = 1'b0;
        tests_run++;
        if (cfg_err !== 1'b1) begin tests_failed++; $display("FAIL err_bad_neuron: got %b, expected 1", cfg_err); end
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        cfg_we = 1'b1; cfg_neuron = 3'd1; cfg_addr = 8'h33; cfg_data = ~model[1][8'h33];
        tick();
        cfg_we = 1'b0;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data = v;
        tick();
        s_valid = 1'b0;
        tests_run++;
        if (m_valid !== 1'b1 || m_data !== model_out(v))
            begin tests_failed++; $display("FAIL err_tables_kept: got v=%b d=%b, expected v=1 d=%b", m_valid, m_data, model_out(v)); end
        tick();
        tick();
        tests_run++;
        if (cfg_err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got %b, expected 1", cfg_err); end
        m_ready = 1'b0;
        s_valid = 1'b1;
        tick();
        s_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tests_run++;
        if (m_valid !== 1'b0 || cfg_err !== 1'b0 || run !== 1'b0)
            begin tests_failed++; $display("FAIL rst_midstream: got v=%b err=%b run=%b, expected 0 0 0", m_valid, cfg_err, run); end
        cfg_done = 1'b1;
        tick();
        cfg_done = 1'b0;
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data = 32'h1000_FFEF;
        tick();
        s_valid = 1'b0;
        tests_run++;
        if (run !== 1'b1 || m_valid !== 1'b1 || m_data !== model_out(32'h1000_FFEF))
            begin tests_failed++; $display("FAIL rst_tables_kept: got run=%b v=%b d=%b, expected run=1 v=1 d=%b", run, m_valid, m_data, model_out(32'h1000_FFEF)); end
        tick();
    endtask

`ifdef LUT_PARITY_EN
    task automatic test_parity();
        tests_run++;
        if (par_err !== 1'b0) begin tests_failed++; $display("FAIL par_clean: got %b, expected 0", par_err); end
        dut.mem[2][8'h33][0] = ~dut.mem[2][8'h33][0];
        model[2][8'h33] = ~model[2][8'h33];
        m_ready = 1'b1;
        s_valid = 1'b1;
        s_data = 32'h0033_0000;
        tick();
        s_valid = 1'b0;
        tests_run++;
        if (m_valid !== 1'b1 || par_err !== 1'b1 || m_data[2] !== model[2][8'h33])
            begin tests_failed++; $display("FAIL par_detect: got v=%b perr=%b d2=%b, expected v=1 perr=1 d2=%b", m_valid, par_err, m_data[2], model[2][8'h33]); end
        tick();
        tick();
        tests_run++;
        if (par_err !== 1'b1) begin tests_failed++; $display("FAIL par_sticky: got %b, expected 1", par_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic_lookup();
        test_back_to_back();
        test_backpressure();
        test_drain();
        test_cfg_err();
`ifdef LUT_PARITY_EN
        test_parity();
`endif
        tick();
        tests_run++;
        if (sb.size() != 0) begin tests_failed++; $display("FAIL sb_leftover: got %0d pending, expected 0", sb.size()); end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
